led_mux_monitor: RTL and testbench

- Receive-side companion of the LED/7-segment multiplexed driver.
- Snoops the shared 8-bit LED data bus and the group select strobes, then rebuilds the per-group bytes: postcode, 4x DIMM fault, fan fault, and both 7-segment digits.
- Decodes the 7-segment patterns back to digit values and checks scan order, select exclusivity and link liveness.
- Used by the on-board debug/BMC mirror path and as a self-check monitor in system simulation.

---
 rtl/led_mux_monitor.sv | 208 ++++++++++++++++++++
 tb/tb_led_mux_monitor.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_mux_monitor.sv
// led_mux_monitor
// Receive-side companion of the multiplexed LED / 7-segment driver. It snoops
// the shared LED data bus and the group selects and rebuilds the per-group
// bytes. It decodes the two 7-segment digits back to values, and it checks
// scan order, select exclusivity and link liveness.
//
// Ports
//   iClk, iRst_n            clock, asynchronous active-low reset
//   iLedData[7:0]           snooped LED data bus
//   iPostCode_Led_Sel, iDimmFlt_CPU*_*_Led_Sel   active-high group selects
//   iPost7Seg1_Sel_N, iPost7Seg2_Sel_N, iFanFlt_Sel_N  active-low selects
//   iClrErr                 synchronous clear of the sticky error flags
//   oPostCode, oDimmFlt_*, oFanFlt   last captured bytes per group
//   oSeg1Val/oSeg2Val       decoded digit (0..15, 16 = dash, 31 = undecodable)
//   oSeg1Dp/oSeg2Dp         captured bit 7 of each digit window
//   oFrameDone              one-cycle pulse at the end of an in-order scan
//   oSeqError/oSelError/oDecError  sticky error flags
//   oLinkTimeout            no capture for TIMEOUT_CYCLES
//   oDbgState[3:0]          {fsm state, expected group index}
module led_mux_monitor #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 40000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic [7:0] iLedData,
    input  logic       iPostCode_Led_Sel,
    input  logic       iDimmFlt_CPU1_1_Led_Sel,
    input  logic       iDimmFlt_CPU1_2_Led_Sel,
    input  logic       iDimmFlt_CPU2_1_Led_Sel,
    input  logic       iDimmFlt_CPU2_2_Led_Sel,
    input  logic       iPost7Seg1_Sel_N,
    input  logic       iPost7Seg2_Sel_N,
    input  logic       iFanFlt_Sel_N,
    input  logic       iClrErr,
    output logic [7:0] oPostCode,
    output logic [7:0] oDimmFlt_CPU1_1,
    output logic [7:0] oDimmFlt_CPU1_2,
    output logic [7:0] oDimmFlt_CPU2_1,
    output logic [7:0] oDimmFlt_CPU2_2,
    output logic [7:0] oFanFlt,
    output logic [4:0] oSeg1Val,
    output logic [4:0] oSeg2Val,
    output logic       oSeg1Dp,
    output logic       oSeg2Dp,
    output logic       oFrameDone,
    output logic       oSeqError,
    output logic       oSelError,
    output logic       oDecError,
    output logic       oLinkTimeout,
    output logic [3:0] oDbgState
);

    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [15:0] TO_LIMIT    = 16'(TIMEOUT_CYCLES);

    typedef enum logic {ST_HUNT = 1'b0, ST_TRACK = 1'b1} state_t;

    // Scan order, bit 0 first: POST, D0, D1, D2, D3, SEG1, SEG2, FAN.
    logic [7:0] selNorm;
    assign selNorm = {~iFanFlt_Sel_N, ~iPost7Seg2_Sel_N, ~iPost7Seg1_Sel_N,
                      iDimmFlt_CPU2_2_Led_Sel, iDimmFlt_CPU2_1_Led_Sel,
                      iDimmFlt_CPU1_2_Led_Sel, iDimmFlt_CPU1_1_Led_Sel,
                      iPostCode_Led_Sel};

    // Selects are normalised before synchronising, so reset yields an idle vector.
    logic [15:0] syncQ [SYNC_STAGES];

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) syncQ[i] <= '0;
        end else begin
            syncQ[0] <= {iLedData, selNorm};
            for (int i = 1; i < SYNC_STAGES; i++) syncQ[i] <= syncQ[i-1];
        end
    end

    logic [7:0] vec, data, prevVec, prevData;
    assign vec  = syncQ[SYNC_STAGES-1][7:0];
    assign data = syncQ[SYNC_STAGES-1][15:8];

    logic oneHot, multiHot, stable, capFire, capDone;
    logic [7:0] settleCnt;
    logic [2:0] capGroup;
    logic [4:0] capDec;

    assign oneHot   = (vec != 8'd0) && ((vec & (vec - 8'd1)) == 8'd0);
    assign multiHot = (vec != 8'd0) && !oneHot;
    assign stable   = (vec == prevVec) && (data == prevData);
    assign capFire  = oneHot && stable && !capDone && (settleCnt == SETTLE_LAST);

    always_comb begin
        capGroup = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (vec[i]) capGroup = 3'(i);
        end
    end

    // Inverse of the common-anode segment table; anything else is undecodable.
    function automatic logic [4:0] segDecode(input logic [6:0] pat);
        case (pat)
            7'h40: segDecode = 5'd0;   7'h79: segDecode = 5'd1;
            7'h24: segDecode = 5'd2;   7'h30: segDecode = 5'd3;
            7'h19: segDecode = 5'd4;   7'h12: segDecode = 5'd5;
            7'h02: segDecode = 5'd6;   7'h78: segDecode = 5'd7;
            7'h00: segDecode = 5'd8;   7'h18: segDecode = 5'd9;
            7'h08: segDecode = 5'd10;  7'h03: segDecode = 5'd11;
            7'h46: segDecode = 5'd12;  7'h21: segDecode = 5'd13;
            7'h06: segDecode = 5'd14;  7'h0E: segDecode = 5'd15;
            7'h3F: segDecode = 5'd16;
            default: segDecode = 5'd31;
        endcase
    endfunction

    assign capDec = segDecode(data[6:0]);

    // Settle tracking: one capture per select window; a data change restarts
    // the count but does not re-arm a window that already captured.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            prevVec   <= '0;
            prevData  <= '0;
            settleCnt <= '0;
            capDone   <= 1'b0;
        end else begin
            prevVec  <= vec;
            prevData <= data;
            if (!stable || !oneHot) settleCnt <= '0;
            else if (!capDone && settleCnt != SETTLE_LAST) settleCnt <= settleCnt + 8'd1;
            if (vec != prevVec) capDone <= 1'b0;
            else if (capFire)   capDone <= 1'b1;
        end
    end

    state_t     state;
    logic [2:0] expIdx;
    logic [15:0] toCnt;
    logic seqSet, decSet, timeoutHit;

    assign seqSet     = capFire && (state == ST_TRACK) && (capGroup != expIdx);
    assign decSet     = capFire && ((capGroup == 3'd5) || (capGroup == 3'd6)) && (capDec == 5'd31);
    assign timeoutHit = (toCnt == TO_LIMIT);
    assign oDbgState  = {state, expIdx};

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oPostCode <= '0; oDimmFlt_CPU1_1 <= '0; oDimmFlt_CPU1_2 <= '0;
            oDimmFlt_CPU2_1 <= '0; oDimmFlt_CPU2_2 <= '0; oFanFlt <= '0;
            oSeg1Val <= '0; oSeg2Val <= '0; oSeg1Dp <= 1'b0; oSeg2Dp <= 1'b0;
            oFrameDone <= 1'b0; oSeqError <= 1'b0; oSelError <= 1'b0;
            oDecError <= 1'b0; oLinkTimeout <= 1'b0;
            state <= ST_HUNT; expIdx <= '0; toCnt <= '0;
        end else begin
            oFrameDone <= 1'b0;

            if (capFire) begin
                case (capGroup)
                    3'd0: oPostCode       <= data;
                    3'd1: oDimmFlt_CPU1_1 <= data;
                    3'd2: oDimmFlt_CPU1_2 <= data;
                    3'd3: oDimmFlt_CPU2_1 <= data;
                    3'd4: oDimmFlt_CPU2_2 <= data;
                    3'd5: begin oSeg1Val <= capDec; oSeg1Dp <= data[7]; end
                    3'd6: begin oSeg2Val <= capDec; oSeg2Dp <= data[7]; end
                    default: oFanFlt <= data;
                endcase
            end

            // Liveness: cleared by any capture, saturates at the limit.
            if (capFire) begin
                toCnt        <= '0;
                oLinkTimeout <= 1'b0;
            end else if (timeoutHit) begin
                oLinkTimeout <= 1'b1;
            end else begin
                toCnt <= toCnt + 16'd1;
            end

            // Scan-order tracker. After FAN the index wraps to 0 so that the
            // next POST is an in-order capture.
            if (capFire) begin
                if (state == ST_HUNT) begin
                    if (capGroup == 3'd0) begin
                        state  <= ST_TRACK;
                        expIdx <= 3'd1;
                    end
                end else if (capGroup == expIdx) begin
                    if (expIdx == 3'd7) oFrameDone <= 1'b1;
                    expIdx <= expIdx + 3'd1;
                end else begin
                    state <= ST_HUNT;
                end
            end else if (timeoutHit) begin
                state <= ST_HUNT;
            end

            // A new error in the same cycle as iClrErr wins.
            if (seqSet)        oSeqError <= 1'b1;
            else if (iClrErr)  oSeqError <= 1'b0;
            if (multiHot)      oSelError <= 1'b1;
            else if (iClrErr)  oSelError <= 1'b0;
            if (decSet)        oDecError <= 1'b1;
            else if (iClrErr)  oDecError <= 1'b0;
        end
    end

endmodule

// File: tb/tb_led_mux_monitor.sv
module tb_led_mux_monitor;

    localparam int SETTLE = 16;
    localparam int SYNC   = 2;
    localparam int TMO    = 40000;
    localparam int GAP    = 6;
    localparam int LAT    = SYNC + SETTLE + 1;

    logic       iClk, iRst_n, iClrErr;
    logic [7:0] iLedData;
    logic       iPostCode_Led_Sel, iDimmFlt_CPU1_1_Led_Sel, iDimmFlt_CPU1_2_Led_Sel;
    logic       iDimmFlt_CPU2_1_Led_Sel, iDimmFlt_CPU2_2_Led_Sel;
    logic       iPost7Seg1_Sel_N, iPost7Seg2_Sel_N, iFanFlt_Sel_N;
    logic [7:0] oPostCode, oDimmFlt_CPU1_1, oDimmFlt_CPU1_2, oDimmFlt_CPU2_1, oDimmFlt_CPU2_2, oFanFlt;
    logic [4:0] oSeg1Val, oSeg2Val;
    logic       oSeg1Dp, oSeg2Dp, oFrameDone, oSeqError, oSelError, oDecError, oLinkTimeout;
    logic [3:0] oDbgState;

    led_mux_monitor #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO), .SYNC_STAGES(SYNC)) dut (
        .iClk(iClk), .iRst_n(iRst_n), .iLedData(iLedData),
        .iPostCode_Led_Sel(iPostCode_Led_Sel),
        .iDimmFlt_CPU1_1_Led_Sel(iDimmFlt_CPU1_1_Led_Sel),
        .iDimmFlt_CPU1_2_Led_Sel(iDimmFlt_CPU1_2_Led_Sel),
        .iDimmFlt_CPU2_1_Led_Sel(iDimmFlt_CPU2_1_Led_Sel),
        .iDimmFlt_CPU2_2_Led_Sel(iDimmFlt_CPU2_2_Led_Sel),
        .iPost7Seg1_Sel_N(iPost7Seg1_Sel_N), .iPost7Seg2_Sel_N(iPost7Seg2_Sel_N),
        .iFanFlt_Sel_N(iFanFlt_Sel_N), .iClrErr(iClrErr),
        .oPostCode(oPostCode), .oDimmFlt_CPU1_1(oDimmFlt_CPU1_1), .oDimmFlt_CPU1_2(oDimmFlt_CPU1_2),
        .oDimmFlt_CPU2_1(oDimmFlt_CPU2_1), .oDimmFlt_CPU2_2(oDimmFlt_CPU2_2), .oFanFlt(oFanFlt),
        .oSeg1Val(oSeg1Val), .oSeg2Val(oSeg2Val), .oSeg1Dp(oSeg1Dp), .oSeg2Dp(oSeg2Dp),
        .oFrameDone(oFrameDone), .oSeqError(oSeqError), .oSelError(oSelError),
        .oDecError(oDecError), .oLinkTimeout(oLinkTimeout), .oDbgState(oDbgState)
    );

    // Clock / reset block
    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    int vectors = 0;
    int miscompares = 0;
    int frameCnt = 0;

    always @(negedge iClk) if (iRst_n && oFrameDone === 1'b1) frameCnt++;

    // Behavioural reference model
    logic [6:0] segTbl [17] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00,
                                7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h3F};
    logic [7:0] mReg [8];
    logic [4:0] mSeg1Val, mSeg2Val;
    logic       mSeg1Dp, mSeg2Dp, mSeqErr, mSelErr, mDecErr, mTimeout;
    bit         mHunt;
    int         mExp, mFrames;

    function automatic logic [4:0] decode_ref(input logic [6:0] p);
        for (int i = 0; i < 17; i++) if (segTbl[i] == p) return 5'(i);
        return 5'd31;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mReg[i] = 8'h00;
        mSeg1Val = 0; mSeg2Val = 0; mSeg1Dp = 0; mSeg2Dp = 0;
        mSeqErr = 0; mSelErr = 0; mDecErr = 0; mTimeout = 0;
        mHunt = 1; mExp = 0;
    endtask

    // Groups must appear POST, D0..D3, SEG1, SEG2, FAN; the frame ends at FAN.
    task automatic model_capture(input int g, input logic [7:0] d);
        mTimeout = 0;
        if (g == 5) begin
            mSeg1Val = decode_ref(d[6:0]); mSeg1Dp = d[7];
            if (mSeg1Val == 31) mDecErr = 1;
        end else if (g == 6) begin
            mSeg2Val = decode_ref(d[6:0]); mSeg2Dp = d[7];
            if (mSeg2Val == 31) mDecErr = 1;
        end else mReg[g] = d;
        if (mHunt) begin
            if (g == 0) begin mHunt = 0; mExp = 1; end
        end else if (g == mExp) begin
            if (g == 7) begin mFrames++; mExp = 0; end
            else mExp = mExp + 1;
        end else begin
            mSeqErr = 1; mHunt = 1;
        end
    endtask

    function automatic logic [59:0] exp_regs();
        return {mReg[0], mReg[1], mReg[2], mReg[3], mReg[4], mReg[7], mSeg1Val, mSeg1Dp, mSeg2Val, mSeg2Dp};
    endfunction
    function automatic logic [59:0] act_regs();
        return {oPostCode, oDimmFlt_CPU1_1, oDimmFlt_CPU1_2, oDimmFlt_CPU2_1, oDimmFlt_CPU2_2, oFanFlt,
                oSeg1Val, oSeg1Dp, oSeg2Val, oSeg2Dp};
    endfunction
    function automatic logic [3:0] exp_errs();
        return {mSeqErr, mSelErr, mDecErr, mTimeout};
    endfunction
    function automatic logic [3:0] act_errs();
        return {oSeqError, oSelError, oDecError, oLinkTimeout};
    endfunction

    // Driver tasks (inputs change on the falling edge)
    task automatic step(input int n);
        repeat (n) @(negedge iClk);
    endtask

    task automatic drive_sel(input logic [7:0] v);
        iPostCode_Led_Sel       = v[0];
        iDimmFlt_CPU1_1_Led_Sel = v[1];
        iDimmFlt_CPU1_2_Led_Sel = v[2];
        iDimmFlt_CPU2_1_Led_Sel = v[3];
        iDimmFlt_CPU2_2_Led_Sel = v[4];
        iPost7Seg1_Sel_N        = ~v[5];
        iPost7Seg2_Sel_N        = ~v[6];
        iFanFlt_Sel_N           = ~v[7];
    endtask

    // A window held well past the settle time followed by an idle decay gap.
    task automatic drive_window(input int g, input logic [7:0] d);
        drive_sel(8'(1 << g));
        iLedData = d;
        step(SETTLE + 10 + $urandom_range(0, 20));
        drive_sel(8'h00);
        step(GAP);
        model_capture(g, d);
    endtask

    task automatic clear_errors();
        iClrErr = 1'b1; step(1); iClrErr = 1'b0; step(1);
        mSeqErr = 0; mSelErr = 0; mDecErr = 0;
    endtask

    function automatic logic [7:0] rand_data(input int g);
        logic [7:0] d;
        if (g == 5 || g == 6) d = {1'($urandom_range(0, 1)), segTbl[$urandom_range(0, 16)]};
        else d = 8'($urandom_range(0, 255));
        return d;
    endfunction

    // Tests
    task automatic test_reset();
        iRst_n = 1'b0; model_reset(); step(3);
        if (act_regs() !== 60'd0) begin miscompares++;
            $display("FAIL reset_regs actual=%h required=0", act_regs()); end
        vectors++;
        if (act_errs() !== 4'd0 || oFrameDone !== 1'b0) begin miscompares++;
            $display("FAIL reset_flags actual=%b/%b required=0000/0", act_errs(), oFrameDone); end
        vectors++;
        iRst_n = 1'b1; step(2);
    endtask

    task automatic test_full_scan();
        logic [7:0] pat [8] = '{8'hA5, 8'h01, 8'h02, 8'h04, 8'h08, 8'h88, 8'h92, 8'h3C};
        int f0 = frameCnt;
        for (int g = 0; g < 8; g++) drive_window(g, pat[g]);
        if (act_regs() !== exp_regs()) begin miscompares++;
            $display("FAIL full_scan_regs actual=%h required=%h", act_regs(), exp_regs()); end
        vectors++;
        if ({oSeg1Val, oSeg1Dp, oSeg2Val, oSeg2Dp} !== {5'd10, 1'b1, 5'd5, 1'b1}) begin miscompares++;
            $display("FAIL full_scan_digits actual=%0d/%b %0d/%b required=10/1 5/1",
                     oSeg1Val, oSeg1Dp, oSeg2Val, oSeg2Dp); end
        vectors++;
        if (frameCnt - f0 !== 1) begin miscompares++;
            $display("FAIL full_scan_frames actual=%0d required=1", frameCnt - f0); end
        vectors++;
        if (act_errs() !== 4'd0) begin miscompares++;
            $display("FAIL full_scan_errors actual=%b required=0000", act_errs()); end
        vectors++;
    endtask

    task automatic test_random_scans();
        for (int s = 0; s < 3; s++) begin
            for (int g = 0; g < 8; g++) begin
                drive_window(g, rand_data(g));
                if (act_regs() !== exp_regs()) begin miscompares++;
                    $display("FAIL rand_scan%0d_g%0d actual=%h required=%h", s, g, act_regs(), exp_regs()); end
                vectors++;
            end
            if (frameCnt !== mFrames || act_errs() !== exp_errs()) begin miscompares++;
                $display("FAIL rand_scan%0d_frames actual=%0d/%b required=%0d/%b",
                         s, frameCnt, act_errs(), mFrames, exp_errs()); end
            vectors++;
        end
    endtask

    task automatic test_glitch();
        logic [7:0] old = mReg[0];
        bit early = 0;
        drive_sel(8'h01); iLedData = 8'h11; step(SETTLE - 2);
        iLedData = 8'h99; step(1);
        iLedData = 8'h22;
        for (int k = 1; k < LAT; k++) begin
            step(1);
            if (oPostCode !== old) early = 1;
        end
        if (early) begin miscompares++;
            $display("FAIL glitch_early actual=changed required=%h until settle", old); end
        vectors++;
        step(1);
        if (oPostCode !== 8'h22) begin miscompares++;
            $display("FAIL glitch_capture actual=%h required=22", oPostCode); end
        vectors++;
        step(10); drive_sel(8'h00); step(GAP);
        model_capture(0, 8'h22);
        if (act_regs() !== exp_regs()) begin miscompares++;
            $display("FAIL glitch_regs actual=%h required=%h", act_regs(), exp_regs()); end
        vectors++;
    endtask

    task automatic test_sel_error();
        drive_sel(8'h03); iLedData = 8'($urandom_range(0, 255));
        step(100); drive_sel(8'h00); step(GAP);
        mSelErr = 1;
        if (act_regs() !== exp_regs()) begin miscompares++;
            $display("FAIL sel_error_regs actual=%h required=%h", act_regs(), exp_regs()); end
        vectors++;
        if (act_errs() !== exp_errs()) begin miscompares++;
            $display("FAIL sel_error_flag actual=%b required=%b", act_errs(), exp_errs()); end
        vectors++;
        clear_errors();
        if (oSelError !== 1'b0) begin miscompares++;
            $display("FAIL sel_error_clear actual=%b required=0", oSelError); end
        vectors++;
    endtask

    task automatic test_skip();
        logic [7:0] d3;
        int f0;
        drive_window(0, rand_data(0));
        drive_window(0, rand_data(0));
        clear_errors();
        f0 = frameCnt;
        drive_window(1, rand_data(1));
        drive_window(2, rand_data(2));
        d3 = rand_data(4);
        drive_window(4, d3);
        if (oSeqError !== 1'b1 || oDimmFlt_CPU2_2 !== d3) begin miscompares++;
            $display("FAIL skip_seq actual=%b/%h required=1/%h", oSeqError, oDimmFlt_CPU2_2, d3); end
        vectors++;
        for (int g = 5; g < 8; g++) drive_window(g, rand_data(g));
        if (frameCnt !== f0) begin miscompares++;
            $display("FAIL skip_no_frame actual=%0d required=%0d", frameCnt, f0); end
        vectors++;
        clear_errors();
        for (int g = 0; g < 8; g++) drive_window(g, rand_data(g));
        if (frameCnt !== f0 + 1 || frameCnt !== mFrames || act_errs() !== exp_errs()) begin miscompares++;
            $display("FAIL skip_recover actual=%0d/%b required=%0d/%b", frameCnt, act_errs(), f0 + 1, exp_errs()); end
        vectors++;
    endtask

    task automatic test_dec_error();
        clear_errors();
        drive_window(5, 8'h7F);
        if (oSeg1Val !== 5'd31 || oDecError !== 1'b1) begin miscompares++;
            $display("FAIL dec_error actual=%0d/%b required=31/1", oSeg1Val, oDecError); end
        vectors++;
        clear_errors();
        drive_window(5, 8'hBF);
        if (oSeg1Val !== 5'd16 || oSeg1Dp !== 1'b1 || act_errs() !== exp_errs()) begin miscompares++;
            $display("FAIL dec_dash actual=%0d/%b/%b required=16/1/%b", oSeg1Val, oSeg1Dp, act_errs(), exp_errs()); end
        vectors++;
    endtask

    task automatic test_timeout();
        step(TMO - 1000);
        if (oLinkTimeout !== 1'b0) begin miscompares++;
            $display("FAIL timeout_early actual=%b required=0", oLinkTimeout); end
        vectors++;
        step(1100);
        mTimeout = 1; mHunt = 1;
        if (act_errs() !== exp_errs()) begin miscompares++;
            $display("FAIL timeout_set actual=%b required=%b", act_errs(), exp_errs()); end
        vectors++;
        drive_window(0, rand_data(0));
        if (act_errs() !== exp_errs() || act_regs() !== exp_regs()) begin miscompares++;
            $display("FAIL timeout_clear actual=%b/%h required=%b/%h", act_errs(), act_regs(), exp_errs(), exp_regs()); end
        vectors++;
    endtask

    task automatic test_reset_mid();
        bit early = 0;
        drive_sel(8'h01); iLedData = 8'h77; step(8);
        iRst_n = 1'b0; model_reset(); step(2);
        if (act_regs() !== 60'd0 || act_errs() !== 4'd0) begin miscompares++;
            $display("FAIL reset_mid_zero actual=%h/%b required=0/0000", act_regs(), act_errs()); end
        vectors++;
        iRst_n = 1'b1;
        for (int k = 1; k < LAT; k++) begin
            step(1);
            if (oPostCode !== 8'h00) early = 1;
        end
        step(1);
        if (early || oPostCode !== 8'h77) begin miscompares++;
            $display("FAIL reset_mid_capture actual=%h early=%0d required=77 early=0", oPostCode, early); end
        vectors++;
        step(5); drive_sel(8'h00); step(GAP);
        model_capture(0, 8'h77);
        if (act_regs() !== exp_regs() || act_errs() !== exp_errs()) begin miscompares++;
            $display("FAIL reset_mid_final actual=%h required=%h", act_regs(), exp_regs()); end
        vectors++;
    endtask

    initial begin
        iRst_n = 1'b0; iClrErr = 1'b0; iLedData = 8'h00; mFrames = 0;
        drive_sel(8'h00);
        model_reset();
        test_reset();
        test_full_scan();
        test_random_scans();
        test_glitch();
        test_sel_error();
        test_skip();
        test_dec_error();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
